// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback path.
// Contents:
//   RF_ADDR_W / RF_DATA_W : default register address and data widths
//   REG_ZERO              : hard-wired zero register index
//   WB_ALU/WB_LSU/WB_CSR  : requester slot indices on the writeback arbiter
package rf_pkg;

    localparam int RF_ADDR_W   = 5;
    localparam int RF_DATA_W   = 32;
    localparam int RF_NUM_REQ  = 3;

    localparam int REG_ZERO    = 0;

    localparam int WB_ALU      = 0;
    localparam int WB_LSU      = 1;
    localparam int WB_CSR      = 2;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter with a registered priority
// pointer. The search starts at the pointer and wraps modulo N; the first set
// request wins. The pointer moves to one past the winner only on accept.
// Ports:
//   clk, reset : clock, asynchronous active-high reset (pointer -> 0)
//   req        : request vector, one bit per requester
//   accept     : the current grant is being consumed this cycle
//   grant      : one-hot grant (all zero when no request)
module rr_arbiter #(
    parameter int N = 3,
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] req,
    input  logic         accept,
    output logic [N-1:0] grant
);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] pos;
    logic [PTR_W:0]   sum;
    logic             any_grant;

    // Walk the N candidates starting at ptr; one extra bit on sum keeps the
    // wrap subtraction exact for non-power-of-two N.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        sum       = '0;
        pos       = '0;
        for (int i = 0; i < N; i++) begin
            sum = {1'b0, ptr} + (PTR_W + 1)'(i);
            if (sum >= (PTR_W + 1)'(N)) begin
                sum = sum - (PTR_W + 1)'(N);
            end
            pos = sum[PTR_W-1:0];
            if (!any_grant && req[pos]) begin
                grant[pos] = 1'b1;
                grant_idx  = pos;
                any_grant  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept && any_grant) begin
            ptr <= (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register file's single write port between
// NUM_REQ writeback requesters and tracks outstanding destinations.
// Handshake: a requester raises req_valid and holds valid/addr/data stable;
// req_ready is a combinational one-hot grant that may depend on req_valid;
// the transfer completes on the rising edge where both are high.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   req_valid/req_addr/req_data: per-requester writeback (packed slices)
//   req_ready                  : one-hot grant
//   rf_reg_write/rf_write_addr/rf_write_data : registered write port
//   rsv_valid/rsv_addr/rsv_ready : destination reservation from issue
//   busy                       : per-register write-outstanding flags
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = RF_NUM_REQ,
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rf_reg_write,
    output logic [ADDR_W-1:0]           rf_write_addr,
    output logic [DATA_W-1:0]           rf_write_data,
    input  logic                        rsv_valid,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic                        rsv_ready,
    output logic [(1<<ADDR_W)-1:0]      busy
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

    logic                    any_grant;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_data;
    logic                    rsv_set;
    logic [(1<<ADDR_W)-1:0]  busy_next;

    // Every grant is consumed the same cycle, so accept is just "a grant exists".
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .accept (any_grant),
        .grant  (req_ready)
    );

    assign any_grant = |req_ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Writes to the zero register are consumed but never reach the file;
    // addr/data still load on any grant and hold otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_reg_write  <= 1'b0;
            rf_write_addr <= '0;
            rf_write_data <= '0;
        end else begin
            rf_reg_write <= any_grant && (sel_addr != ZERO_ADDR);
            if (any_grant) begin
                rf_write_addr <= sel_addr;
                rf_write_data <= sel_data;
            end
        end
    end

    assign rsv_ready = (rsv_addr == ZERO_ADDR) || !busy[rsv_addr];
    assign rsv_set   = rsv_valid && rsv_ready && (rsv_addr != ZERO_ADDR);

    // Clear is applied first so a same-edge reservation of the register
    // being written wins: the new reservation supersedes the retiring write.
    always_comb begin
        busy_next = busy;
        if (rf_reg_write) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (rsv_set) begin
            busy_next[rsv_addr] = 1'b1;
        end
        busy_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 1 << AW;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            rf_reg_write;
  logic [AW-1:0]   rf_write_addr;
  logic [DW-1:0]   rf_write_data;
  logic            rsv_valid;
  logic [AW-1:0]   rsv_addr;
  logic            rsv_ready;
  logic [NR-1:0]   busy;

  regfile_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_ready     (req_ready),
    .rf_reg_write  (rf_reg_write),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .rsv_valid     (rsv_valid),
    .rsv_addr      (rsv_addr),
    .rsv_ready     (rsv_ready),
    .busy          (busy)
  );

  // requester-side state
  logic [N-1:0]  v;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];

  assign req_valid = v;
  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*DW +: DW] = d[i];
    end
  end

  // behavioural model
  int            m_ptr;
  logic [NR-1:0] m_busy;
  logic          m_wr;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;

  int checks = 0;
  int fails  = 0;

  logic [N-1:0] last_ready;
  logic         last_rsv_ready;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr   = 0;
    m_busy  = '0;
    m_wr    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // first valid requester at or after the pointer, wrapping; -1 when none
  function automatic int exp_grant();
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Called at a negedge with inputs already driven: checks every output
  // against the model, then advances the model across the next posedge.
  task automatic step(output int g);
    logic [N-1:0]  eg;
    logic [NR-1:0] nb;
    logic          rr;
    #1;
    g  = exp_grant();
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    rr = (rsv_addr == 0) || !m_busy[rsv_addr];
    last_ready     = req_ready;
    last_rsv_ready = rsv_ready;
    check("req_ready", req_ready, eg);
    check("rsv_ready", rsv_ready, rr);
    check("rf_reg_write", rf_reg_write, m_wr);
    check("rf_write_addr", rf_write_addr, m_waddr);
    check("rf_write_data", rf_write_data, m_wdata);
    check("busy", busy, m_busy);
    nb = m_busy;
    if (m_wr) nb[m_waddr] = 1'b0;
    if (rsv_valid && rr && rsv_addr != 0) nb[rsv_addr] = 1'b1;
    @(posedge clk);
    m_busy = nb;
    if (g >= 0) begin
      m_ptr   = (g + 1) % N;
      m_wr    = (a[g] != 0);
      m_waddr = a[g];
      m_wdata = d[g];
    end else begin
      m_wr = 1'b0;
    end
    @(negedge clk);
  endtask

  int g;
  int gseq [6];
  logic [AW-1:0] wseq [$];

  initial begin
    reset     = 1'b1;
    v         = '0;
    rsv_valid = 1'b0;
    rsv_addr  = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      d[i] = '0;
    end
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_wr", rf_reg_write, 0);
    check("rst_waddr", rf_write_addr, 0);
    check("rst_rsv_ready", rsv_ready, 1);
    check("rst_req_ready", req_ready, 0);
    @(negedge clk);

    // round robin, all valid continuously
    v = 3'b111;
    a[0] = 5; a[1] = 6; a[2] = 7;
    d[0] = 32'hA; d[1] = 32'hB; d[2] = 32'hC;
    for (int k = 0; k < 6; k++) begin
      step(g);
      gseq[k] = g;
      if (rf_reg_write) wseq.push_back(rf_write_addr);
    end
    for (int k = 0; k < 6; k++) check("rr_grant", gseq[k], k % 3);
    check("rr_wcount", wseq.size(), 6);
    if (wseq.size() >= 4) begin
      check("rr_w0", wseq[0], 5);
      check("rr_w1", wseq[1], 6);
      check("rr_w2", wseq[2], 7);
      check("rr_w3", wseq[3], 5);
    end
    v = '0;

    // zero register
    v[2] = 1'b1; a[2] = 0; d[2] = 32'hDEAD;
    step(g);
    v[2] = 1'b0;
    check("zero_ready", last_ready, 3'b100);
    check("zero_wr", rf_reg_write, 0);
    check("zero_busy", busy, 0);
    step(g);

    // scoreboard set / WAW stall / clear
    rsv_valid = 1'b1; rsv_addr = 10;
    step(g);
    check("sb_set", busy[10], 1);
    step(g);
    check("sb_waw_stall", last_rsv_ready, 0);
    rsv_valid = 1'b0;
    v[0] = 1'b1; a[0] = 10; d[0] = 32'h55;
    step(g);
    v[0] = 1'b0;
    check("sb_wr_high", rf_reg_write, 1);
    check("sb_still_busy", busy[10], 1);
    step(g);
    check("sb_cleared", busy[10], 0);

    // simultaneous set and clear on r3
    v[0] = 1'b1; a[0] = 3; d[0] = 32'h33;
    step(g);
    v[0] = 1'b0;
    check("sim_wr", rf_reg_write, 1);
    check("sim_waddr", rf_write_addr, 3);
    rsv_valid = 1'b1; rsv_addr = 3;
    step(g);
    rsv_valid = 1'b0;
    check("sim_set_wins", busy[3], 1);

    // asynchronous reset mid-transfer, requester 1 granted
    rsv_valid = 1'b1; rsv_addr = 9;
    step(g);
    rsv_valid = 1'b0;
    v[1] = 1'b1; a[1] = 12; d[1] = 32'h77;
    step(g);
    check("mid_wr_before", rf_reg_write, 1);
    reset = 1'b1;
    #1;
    check("async_wr", rf_reg_write, 0);
    check("async_busy", busy, 0);
    v = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // hold / stability after reset
    v[0] = 1'b1; a[0] = 8; d[0] = 32'h1;
    v[1] = 1'b1; a[1] = 4; d[1] = 32'h12345678;
    step(g);
    v[0] = 1'b0;
    check("hold_g0", last_ready, 3'b001);
    step(g);
    v[1] = 1'b0;
    check("hold_g1", last_ready, 3'b010);
    check("hold_wr", rf_reg_write, 1);
    check("hold_addr", rf_write_addr, 4);
    check("hold_data", rf_write_data, 32'h12345678);

    // randomized traffic
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && $urandom_range(0, 99) < 55) begin
          v[i] = 1'b1;
          a[i] = AW'($urandom_range(0, 7));
          d[i] = $urandom;
        end
      end
      rsv_valid = ($urandom_range(0, 99) < 40);
      rsv_addr  = AW'($urandom_range(0, 7));
      step(g);
      if (g >= 0) v[g] = 1'b0;
    end
    v = '0;
    rsv_valid = 1'b0;
    step(g);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
